// File: rtl/mm_pkg.sv
// Shared constants and types for the 3x3 matrix-multiply job arbiter.
// Matrices are packed row-major, one ELEM_W-bit element per entry.
package mm_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned DIM    = 3;
  localparam int unsigned MAT_W  = ELEM_W * DIM * DIM;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStart,
    StWait,
    StResp
  } state_e;

  // LSB position of element (i, j) inside a packed matrix.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j);
    return ELEM_W * (DIM * i + j);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the pointer's requester wins,
// a lone request always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mm_job_arbiter.sv
// Shares one 3x3 systolic matmul array between two requesters: latches operands,
// clears and launches the array, waits under a watchdog and returns tagged results.
module mm_job_arbiter
  import mm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [MAT_W-1:0] a0,
  input  logic [MAT_W-1:0] b0,
  input  logic [MAT_W-1:0] a1,
  input  logic [MAT_W-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             arr_clear,
  output logic             arr_start,
  output logic [MAT_W-1:0] arr_a,
  output logic [MAT_W-1:0] arr_b,
  input  logic             arr_done,
  input  logic [MAT_W-1:0] arr_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [MAT_W-1:0] rsp_c
);

  localparam int unsigned WdW = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [MAT_W-1:0] a_q, a_d;
  logic [MAT_W-1:0] b_q, b_d;
  logic [MAT_W-1:0] c_q, c_d;
  logic             err_q, err_d;
  logic [1:0]       grant;

  rr_arb2 u_rr_arb2 (
    .req   ({req1, req0}),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    wd_d      = wd_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    err_d     = err_q;
    ack0      = 1'b0;
    ack1      = 1'b0;
    arr_clear = 1'b0;
    arr_start = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          owner_d = grant[1];
          a_d     = grant[1] ? a1 : a0;
          b_d     = grant[1] ? b1 : b0;
          state_d = StClear;
        end
      end
      StClear: begin
        arr_clear = 1'b1;
        ack0      = ~owner_q;
        ack1      = owner_q;
        wd_d      = '0;
        state_d   = StStart;
      end
      StStart: begin
        // Watchdog reads 0 in the launch cycle, so expiry lands TIMEOUT cycles after it.
        arr_start = 1'b1;
        wd_d      = wd_q + WdW'(1);
        state_d   = StWait;
      end
      StWait: begin
        if (arr_done) begin
          c_d     = arr_c;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          c_d     = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          ptr_d   = ~owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      wd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign arr_a   = a_q;
  assign arr_b   = b_q;
  assign rsp_id  = owner_q;
  assign rsp_err = err_q;
  assign rsp_c   = c_q;

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Bench for mm_job_arbiter: behavioural array model plus a response scoreboard
// fed when each request is driven and drained on every response handshake.
module tb_mm_job_arbiter;
  import mm_pkg::*;

  localparam int unsigned TIMEOUT = 32;

  typedef struct packed {
    logic             id;
    logic             err;
    logic [MAT_W-1:0] c;
  } rsp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [MAT_W-1:0] a0, b0, a1, b1;
  logic             ack0, ack1, busy, arr_clear, arr_start;
  logic [MAT_W-1:0] arr_a, arr_b, arr_c, rsp_c;
  logic             arr_done, rsp_valid, rsp_ready, rsp_id, rsp_err;

  int   n_total = 0;
  int   n_bad = 0;
  int   arr_lat = -1;
  int   stray_cnt = 0;
  rsp_t sb[$];

  always #5 clk = ~clk;

  mm_job_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .ack0      (ack0),
    .ack1      (ack1),
    .busy      (busy),
    .arr_clear (arr_clear),
    .arr_start (arr_start),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .arr_done  (arr_done),
    .arr_c     (arr_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_c     (rsp_c)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] matmul(input logic [MAT_W-1:0] a,
                                               input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0]  c;
    logic [ELEM_W-1:0] s;
    c = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        s = '0;
        for (int unsigned k = 0; k < DIM; k++) begin
          s += a[elem_lsb(i, k) +: ELEM_W] * b[elem_lsb(k, j) +: ELEM_W];
        end
        c[elem_lsb(i, j) +: ELEM_W] = s;
      end
    end
    return c;
  endfunction

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] m;
    for (int unsigned i = 0; i < DIM; i++) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        m[elem_lsb(i, j) +: ELEM_W] = 8'($urandom_range(0, 255));
      end
    end
    return m;
  endfunction

  // A done pulse that arrives no later than the watchdog expiry still wins.
  function automatic bit times_out(input int lat);
    return (lat < 0) || (lat >= int'(TIMEOUT));
  endfunction

  // Array model: done pulse arr_lat cycles after arr_start (never when negative).
  initial begin
    int cnt;
    int stray_seen;
    cnt = -1;
    stray_seen = 0;
    arr_done = 1'b0;
    arr_c = '0;
    forever begin
      @(negedge clk);
      arr_done = 1'b0;
      if (reset) begin
        cnt = -1;
      end else if (arr_start) begin
        cnt = arr_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          arr_done = 1'b1;
          arr_c = matmul(arr_a, arr_b);
          cnt = -1;
        end
      end
      if (stray_cnt != stray_seen) begin
        arr_done = 1'b1;
        arr_c = rand_mat();
        stray_seen = stray_cnt;
      end
    end
  end

  // Response monitor: pop the scoreboard on every accepted response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_id", rsp_id, e.id);
          check_eq("rsp_err", rsp_err, e.err);
          check_eq("rsp_c", rsp_c, e.c);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "bench timed out");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input bit id, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                          input int lat);
    rsp_t e;
    e.id  = id;
    e.err = times_out(lat);
    e.c   = e.err ? '0 : matmul(a, b);
    sb.push_back(e);
  endtask

  task automatic raise(input bit id, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                       input int lat, input bit track);
    arr_lat = lat;
    if (id) begin
      req1 = 1'b1; a1 = a; b1 = b;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b;
    end
    if (track) push_exp(id, a, b, lat);
  endtask

  task automatic expect_ack(input bit id, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                            input bit drop);
    step(1);
    check_eq("ack", {ack1, ack0}, id ? 2'b10 : 2'b01);
    check_eq("arr_clear", arr_clear, 1'b1);
    check_eq("arr_a", arr_a, a);
    check_eq("arr_b", arr_b, b);
    if (drop) begin
      if (id) req1 = 1'b0;
      else req0 = 1'b0;
    end
  endtask

  // From CLEAR: step into START, then count cycles until rsp_valid.
  task automatic expect_run(input int lat);
    int n;
    step(1);
    check_eq("arr_start", {arr_start, arr_clear}, 2'b10);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    check_eq("rsp_latency", n, times_out(lat) ? TIMEOUT : lat + 1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"}, {ack0, ack1, busy, arr_clear, arr_start, rsp_valid, rsp_id, rsp_err},
             '0);
    check_eq({tag, "_arr_a"}, arr_a, '0);
    check_eq({tag, "_arr_b"}, arr_b, '0);
    check_eq({tag, "_rsp_c"}, rsp_c, '0);
  endtask

  initial begin
    logic [MAT_W-1:0] ident, seq, ma, mb, mc, md, exp_c;
    ident = '0;
    seq = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        ident[elem_lsb(i, j) +: ELEM_W] = (i == j) ? 8'd1 : 8'd0;
        seq[elem_lsb(i, j) +: ELEM_W] = 8'(DIM * i + j + 1);
      end
    end
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; rsp_ready = 1'b1;
    step(3);
    check_zero("reset");
    reset = 1'b0;
    step(1);

    // Single job, identity * 1..9, array latency 9.
    raise(0, ident, seq, 9, 1);
    expect_ack(0, ident, seq, 1);
    expect_run(9);
    check_eq("single_rsp_c", rsp_c, seq);
    step(1);
    check_eq("single_idle", busy, 1'b0);

    // Done pulse outside WAIT must not start anything.
    stray_cnt++;
    step(3);
    check_eq("stray_done", {busy, rsp_valid}, 2'b00);

    // Contention from reset with both requests held: grants alternate 0,1,0,1.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    ma = rand_mat(); mb = rand_mat(); mc = rand_mat(); md = rand_mat();
    arr_lat = 3;
    req0 = 1'b1; a0 = ma; b0 = mb;
    req1 = 1'b1; a1 = mc; b1 = md;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push_exp(0, ma, mb, 3);
        expect_ack(0, ma, mb, 0);
      end else begin
        push_exp(1, mc, md, 3);
        expect_ack(1, mc, md, 0);
      end
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      expect_run(3);
      step(1);
    end
    check_eq("contention_idle", busy, 1'b0);

    // Timeout: array never completes, then a normal job follows.
    ma = rand_mat(); mb = rand_mat();
    raise(0, ma, mb, -1, 1);
    expect_ack(0, ma, mb, 1);
    expect_run(-1);
    check_eq("timeout_flags", {rsp_err, rsp_c == '0}, 2'b11);
    step(1);
    ma = rand_mat(); mb = rand_mat();
    raise(1, ma, mb, 7, 1);
    expect_ack(1, ma, mb, 1);
    expect_run(7);
    step(1);

    // Done on the exact watchdog expiry cycle: done wins.
    ma = rand_mat(); mb = rand_mat();
    raise(0, ma, mb, int'(TIMEOUT) - 1, 1);
    expect_ack(0, ma, mb, 1);
    expect_run(int'(TIMEOUT) - 1);
    check_eq("collision_err", rsp_err, 1'b0);
    step(1);

    // Backpressure: response held 20 cycles while req1 waits unacknowledged.
    rsp_ready = 1'b0;
    ma = rand_mat(); mb = rand_mat();
    exp_c = matmul(ma, mb);
    raise(0, ma, mb, 4, 1);
    expect_ack(0, ma, mb, 1);
    expect_run(4);
    mc = rand_mat(); md = rand_mat();
    raise(1, mc, md, 6, 1);
    for (int k = 0; k < 20; k++) begin
      step(1);
      check_eq("bp_hold", {rsp_valid, rsp_id, rsp_err, ack1, ack0, rsp_c},
               {5'b10000, exp_c});
    end
    rsp_ready = 1'b1;
    step(1);
    check_eq("bp_release", {busy, ack1}, 2'b00);
    expect_ack(1, mc, md, 1);
    expect_run(6);
    step(1);

    // Reset while in WAIT aborts the job with no response.
    ma = rand_mat(); mb = rand_mat();
    raise(1, ma, mb, -1, 0);
    expect_ack(1, ma, mb, 1);
    step(4);
    check_eq("wait_busy", {busy, rsp_valid}, 2'b10);
    reset = 1'b1;
    step(1);
    check_zero("midjob_reset");
    reset = 1'b0;
    step(2);
    check_eq("post_reset_quiet", {busy, rsp_valid}, 2'b00);
    ma = rand_mat(); mb = rand_mat();
    raise(1, ma, mb, 5, 1);
    expect_ack(1, ma, mb, 1);
    expect_run(5);
    step(1);
    check_eq("final_idle", busy, 1'b0);

    step(2);
    check_eq("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mm_job_arbiter.md
# mm_job_arbiter

Shares the single 3x3 systolic matrix-multiply array between two requesters (requester 0 and requester 1). For each job it latches the operands, clears the array's accumulators and launches the array. It then waits for completion under a watchdog and returns the 9 results with a requester tag over a valid/ready response channel. The block sits between the client logic and the array core. It is the only driver of the array's clear and start inputs.

## Interface
- TIMEOUT, 32: cycles spent in WAIT before the job is aborted with an error; must be ≥ 12.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req0, req1  in  1  job request, held high until the matching ack
- a0, b0, a1, b1  in  72  packed operand matrices; element ij is at bits [8*(3i+j)+7 : 8*(3i+j)]
- ack0, ack1  out  1  one-cycle pulse: operands latched, request accepted
- busy  out  1  high in every state except IDLE
- arr_clear  out  1  one-cycle accumulator clear to the array
- arr_start  out  1  one-cycle launch to the array
- arr_a, arr_b  out  72  latched operands, stable from CLEAR until the job returns to IDLE
- arr_done  in  1  array completion pulse
- arr_c  in  72  array results (9 × 8 bits, same packing), valid in the cycle arr_done is high
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that owns the response
- rsp_err  out  1  set when the job timed out
- rsp_c  out  72  captured results

## Operation
- States: IDLE, CLEAR, START, WAIT, RESP.
- IDLE
  - If any request is high, grant one request and latch its operands into arr_a/arr_b.
  - Record the owner, register the matching ack and go to CLEAR.
- CLEAR: arr_clear=1 and ack<owner>=1 for this cycle; go to START.
- START: arr_start=1 for this cycle; clear the watchdog to 0; go to WAIT.
- WAIT
  - On arr_done: capture arr_c into rsp_c, rsp_err=0, go to RESP.
  - Otherwise, when the watchdog reaches TIMEOUT-1: rsp_c=0, rsp_err=1, go to RESP.
  - Otherwise increment the watchdog.
- RESP
  - rsp_valid=1, rsp_id=owner.
  - On rsp_valid && rsp_ready: set the round-robin pointer to the non-owner, drop rsp_valid, go to IDLE.
- Arbitration is 2-way round-robin. When both requests are high, the pointer's requester wins. With a single request, that request wins regardless of the pointer.
- Requesters drop their request in the cycle after they see ack. A request still high when the block re-enters IDLE is a new job.
- Arithmetic: the block does no arithmetic. Results pass through unmodified at 8 bits per element.

## Timing
- Reset values:
  - State IDLE, pointer 0, watchdog 0.
  - All outputs 0: ack0, ack1, busy, arr_clear, arr_start, arr_a, arr_b, rsp_valid, rsp_id, rsp_err, rsp_c.
- Job latency, with req sampled in IDLE at cycle 0:
  - Cycle 1: ack and arr_clear.
  - Cycle 2: arr_start.
  - Cycle 2+L: arr_done, where L is the array latency.
  - Cycle 3+L: rsp_valid.
- Minimum turnaround: IDLE is re-entered the cycle after rsp_ready is accepted, so a back-to-back request is granted one cycle later.
- Boundary conditions:
  - arr_done and watchdog expiry in the same cycle: done wins, rsp_err=0.
  - arr_done outside WAIT is ignored.
  - Requests arriving while busy are not acked; they wait.
  - rsp_ready low holds RESP indefinitely; rsp_c, rsp_id and rsp_err stay stable.
- Reset mid-job aborts immediately to the reset values. No response is produced, and the pointer returns to 0.

## Structure
- Package mm_pkg:
  - ELEM_W=8, DIM=3, MAT_W=72.
  - State enum.
  - A function for element-index packing.
- Sub-module rr_arb2: 2-way round-robin grant logic.
  - Inputs: req[1:0], pointer.
  - Output: one-hot grant.
- FSM, operand/result registers and watchdog stay in mm_job_arbiter.

## Test plan
- Single job: req0 with a0=identity, b0 elements 1..9; array model returns the product after L=9 → ack0 at cycle 1, arr_start at cycle 2, rsp_valid at cycle 12, rsp_id=0, rsp_c=b0, rsp_err=0.
- Contention: req0 and req1 both high from reset → req0 served first, then req1 (pointer now 1); pointer returns to 0 afterwards. With both requests held continuously, grants alternate 0,1,0,1.
- Timeout: array never asserts done, TIMEOUT=32 → rsp_valid with rsp_err=1, rsp_c=0 exactly 32 cycles after arr_start; the next job runs normally.
- Backpressure: rsp_ready held low for 20 cycles → rsp_valid, rsp_c and rsp_id stable; req1 receives no ack until the response is accepted.
- Done/timeout collision: arr_done on the expiry cycle → rsp_err=0, results captured.
- Reset in WAIT: all outputs 0 the next cycle, no rsp_valid; a fresh req1 completes normally.
